// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one external combinational ALU between two requesters; ports clk, rst_n, req_*_i/o, resp_*_i/o, busy_o, alu_*_o/i
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid_i,
  output logic [1:0]         req_ready_o,
  input  logic [2*OPW-1:0]   req_op_i,
  input  logic [2*WIDTH-1:0] req_a_i,
  input  logic [2*WIDTH-1:0] req_b_i,
  output logic [1:0]         resp_valid_o,
  input  logic [1:0]         resp_ready_i,
  output logic [WIDTH-1:0]   resp_result_o,
  output logic               resp_overflow_o,
  output logic               busy_o,
  output logic [WIDTH-1:0]   alu_a_o,
  output logic [WIDTH-1:0]   alu_b_o,
  output logic [OPW-1:0]     alu_s_o,
  input  logic [WIDTH-1:0]   alu_result_i,
  input  logic               alu_overflow_i
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q;
  logic             last_q, gnt_q, gnt_d, ovf_q;
  logic [1:0]       resp_valid_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [OPW-1:0]   op_q;
  logic             logic_op;
  always_comb begin
    gnt_d       = (&req_valid_i) ? ~last_q : req_valid_i[1];
    req_ready_o = (state_q == IDLE && |req_valid_i) ? (gnt_d ? 2'b10 : 2'b01) : 2'b00;
    logic_op    = op_q inside {OPW'(1), OPW'(2), OPW'(3)};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      gnt_q        <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      ovf_q        <= 1'b0;
      resp_valid_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: if (|(req_valid_i & req_ready_o)) begin
          op_q    <= gnt_d ? req_op_i[2*OPW-1:OPW] : req_op_i[OPW-1:0];
          a_q     <= gnt_d ? req_a_i[2*WIDTH-1:WIDTH] : req_a_i[WIDTH-1:0];
          b_q     <= gnt_d ? req_b_i[2*WIDTH-1:WIDTH] : req_b_i[WIDTH-1:0];
          gnt_q   <= gnt_d;
          state_q <= EXEC;
        end
        EXEC: begin
          result_q     <= alu_result_i;
          ovf_q        <= alu_overflow_i & ~logic_op;
          resp_valid_q <= gnt_q ? 2'b10 : 2'b01;
          state_q      <= RESP;
        end
        RESP: if (resp_ready_i[gnt_q]) begin
          resp_valid_q <= 2'b00;
          last_q       <= gnt_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign resp_valid_o    = resp_valid_q;
  assign resp_result_o   = result_q;
  assign resp_overflow_o = ovf_q;
  assign busy_o          = state_q != IDLE;
  assign alu_a_o         = a_q;
  assign alu_b_o         = b_q;
  assign alu_s_o         = op_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed-vector bench for alu_arbiter with a behavioural ALU attached
module tb_alu_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [1:0]  req_valid = '0, req_ready, resp_valid, resp_ready = '0;
  logic [5:0]  req_op = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic [31:0] resp_result, alu_a, alu_b, alu_result;
  logic        resp_overflow, busy, alu_overflow, force_ovf = 1'b0, ovf;
  logic [2:0]  alu_s;
  int          vecs = 0, errs = 0;
  always #5 clk = ~clk;
  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_result_o(resp_result), .resp_overflow_o(resp_overflow),
    .busy_o(busy),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_s_o(alu_s),
    .alu_result_i(alu_result), .alu_overflow_i(alu_overflow)
  );
  always_comb begin
    alu_result = '0;
    ovf        = 1'b0;
    case (alu_s)
      3'd0: begin alu_result = -alu_a; ovf = alu_a == 32'h8000_0000; end
      3'd1: alu_result = alu_a & alu_b;
      3'd2: alu_result = alu_a ^ alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: begin alu_result = alu_a - 32'd1; ovf = alu_a == 32'h8000_0000; end
      3'd5: begin alu_result = alu_a + alu_b; ovf = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]); end
      3'd6: begin alu_result = alu_a - alu_b; ovf = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]); end
      default: begin alu_result = alu_a + 32'd1; ovf = alu_a == 32'h7FFF_FFFF; end
    endcase
    alu_overflow = ovf | force_ovf;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic check_resp(input string tag, input logic [1:0] v, input logic [31:0] r, input logic o);
    check({tag, "_valid"}, 64'(resp_valid), 64'(v));
    check({tag, "_result"}, 64'(resp_result), 64'(r));
    check({tag, "_ovf"}, 64'(resp_overflow), 64'(o));
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'd0);
    check_resp(tag, 2'b00, 32'd0, 1'b0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_alu"}, {29'd0, alu_s, alu_a}, 64'd0);
    check({tag, "_alu_b"}, 64'(alu_b), 64'd0);
  endtask
  initial begin
    tick; tick;
    check_reset("reset");
    rst_n = 1'b1;
    tick;
    // 1: signed add overflow, latency check
    req_valid = 2'b01; req_op[2:0] = 3'b101; req_a[31:0] = 32'h7FFF_FFFF; req_b[31:0] = 32'h1; resp_ready = 2'b11;
    #1 check("t1_ready", 64'(req_ready), 64'b01);
    tick; req_valid = 2'b00;
    #1 check("t1_exec_busy", 64'(busy), 64'd1);
    check("t1_exec_ready", 64'(req_ready), 64'd0);
    check("t1_exec_valid", 64'(resp_valid), 64'd0);
    check("t1_alu", {29'd0, alu_s, alu_a}, {29'd5, 32'h7FFF_FFFF});
    tick;
    check_resp("t1_resp", 2'b01, 32'h8000_0000, 1'b1);
    tick;
    check("t1_idle_valid", 64'(resp_valid), 64'd0);
    check("t1_idle_busy", 64'(busy), 64'd0);
    check("t1_alu_hold", 64'(alu_a), 64'h7FFF_FFFF);
    // 2: tie after reset, requester 0 first
    rst_n = 1'b0; tick; rst_n = 1'b1; tick;
    req_valid = 2'b11;
    req_op = {3'b110, 3'b001};
    req_a = {32'h1234_5678, 32'hAAAA_5555};
    req_b = {32'h8765_4321, 32'hF0F0_F0F0};
    #1 check("t2_ready0", 64'(req_ready), 64'b01);
    tick; req_valid = 2'b10;
    #1 check("t2_wait_ready", 64'(req_ready), 64'd0);
    tick;
    check_resp("t2_r0", 2'b01, 32'hA0A0_5050, 1'b0);
    tick;
    #1 check("t2_ready1", 64'(req_ready), 64'b10);
    tick; req_valid = 2'b00;
    tick;
    check_resp("t2_r1", 2'b10, 32'h8ACF_1357, 1'b1);
    tick;
    // 3: continuous contention alternates grants
    req_valid = 2'b11;
    req_op = {3'b010, 3'b111};
    req_a = {32'hFF00_FF00, 32'h0000_0010};
    req_b = {32'h0F0F_0F0F, 32'h0};
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("t3_ready%0d", k), 64'(req_ready), (k % 2) ? 64'b10 : 64'b01);
      tick; tick;
      check_resp($sformatf("t3_resp%0d", k), (k % 2) ? 2'b10 : 2'b01, (k % 2) ? 32'hF00F_F00F : 32'h11, 1'b0);
      tick;
    end
    // 4: response held while unaccepted, other ready bit ignored, pending req1 waits
    req_valid = 2'b01; req_op = {3'b011, 3'b111};
    req_a = {32'hF0F0_F0F0, 32'h7FFF_FFFF}; req_b = {32'h0F0F_0F0F, 32'h0};
    resp_ready = 2'b10;
    #1 check("t4_ready", 64'(req_ready), 64'b01);
    tick; req_valid = 2'b10;
    tick;
    for (int k = 0; k < 5; k++) begin
      check_resp($sformatf("t4_hold%0d", k), 2'b01, 32'h8000_0000, 1'b1);
      check($sformatf("t4_ready_hold%0d", k), 64'(req_ready), 64'd0);
      tick;
    end
    resp_ready = 2'b01;
    tick;
    // 5: logic op masks ALU overflow
    force_ovf = 1'b1; resp_ready = 2'b10;
    #1 check("t5_ready", 64'(req_ready), 64'b10);
    tick; req_valid = 2'b00;
    tick;
    check_resp("t5_resp", 2'b10, 32'hFFFF_FFFF, 1'b0);
    tick; force_ovf = 1'b0;
    check("t5_idle", 64'(busy), 64'd0);
    // dropping valid before transfer latches nothing
    req_valid = 2'b01; req_op[2:0] = 3'b000; req_a[31:0] = 32'h1;
    #1 check("drop_ready", 64'(req_ready), 64'b01);
    req_valid = 2'b00;
    tick;
    check("drop_busy", 64'(busy), 64'd0);
    check("drop_alu", 64'(alu_a), 64'hF0F0_F0F0);
    // 6: reset during EXEC discards the transaction
    resp_ready = 2'b11; req_valid = 2'b01; req_op[2:0] = 3'b101;
    tick; req_valid = 2'b00;
    check("t6_exec", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1 check_reset("t6_rst");
    tick; rst_n = 1'b1;
    tick;
    check("t6_no_resp", 64'(resp_valid), 64'd0);
    req_valid = 2'b01; req_op[2:0] = 3'b100; req_a[31:0] = 32'h5; req_b[31:0] = 32'h0;
    #1 check("t6_ready", 64'(req_ready), 64'b01);
    tick; req_valid = 2'b00;
    check("t6_n1", 64'(resp_valid), 64'd0);
    tick;
    check_resp("t6_resp", 2'b01, 32'h4, 1'b0);
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
